// File: rtl/me_scheduler.sv
// me_scheduler: walks NUM_BLK template blocks through the me_double engine,
// one req/ack handshake per block, collecting per-block and run results.
module me_scheduler #(
  parameter int NUM_BLK = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IDX_W-1:0]   blk_idx,
  output logic               me_req,
  input  logic               me_ack,
  input  logic [15:0]        me_min_sad,
  input  logic [9:0]         me_min_mvec,
  output logic               res_valid,
  output logic [IDX_W-1:0]   res_idx,
  output logic [15:0]        res_sad,
  output logic [9:0]         res_mvec,
  output logic [16+IDX_W-1:0] total_sad,
  output logic [IDX_W-1:0]   best_idx
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLK - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_REQ, S_CAPT,
    S_REL, S_NEXT, S_DONE, S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [WD_W-1:0]       wd_q;
  logic [IDX_W-1:0]      blk_idx_q;
  logic [IDX_W-1:0]      res_idx_q;
  logic [15:0]           res_sad_q;
  logic [9:0]            res_mvec_q;
  logic [16+IDX_W-1:0]   total_q;
  logic [IDX_W-1:0]      best_idx_q;
  logic [15:0]           best_sad_q;
  logic                  err_q;
  logic                  wd_hit;
  logic                  last_blk;
  logic                  go;

  assign wd_hit   = (wd_q == WD_MAX);
  assign last_blk = (blk_idx_q == LAST_IDX);
  assign go       = (state_q == S_IDLE) && start;

  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign blk_idx   = blk_idx_q;
  assign res_idx   = res_idx_q;
  assign res_sad   = res_sad_q;
  assign res_mvec  = res_mvec_q;
  assign total_sad = total_q;
  assign best_idx  = best_idx_q;

  // State register; reset drops me_req at once since me_req decodes state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; an ack wins over a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    me_req    = 1'b0;
    done      = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: if (!me_ack) state_d = S_REQ;
      S_REQ: begin
        me_req = 1'b1;
        if (me_ack)      state_d = S_CAPT;
        else if (wd_hit) state_d = S_ERR;
      end
      S_CAPT: begin
        me_req    = 1'b1;
        res_valid = 1'b1;
        state_d   = S_REL;
      end
      S_REL: begin
        if (!me_ack)     state_d = S_NEXT;
        else if (wd_hit) state_d = S_ERR;
      end
      S_NEXT:  state_d = last_blk ? S_DONE : S_SETUP;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (!me_ack) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog: restarts on entry to REQ/REL, counts while waiting there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if ((state_q == S_REQ || state_q == S_REL) &&
                 state_d == state_q) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end

  // Block index, result capture, running total/best and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_idx_q  <= '0;
      res_idx_q  <= '0;
      res_sad_q  <= '0;
      res_mvec_q <= '0;
      total_q    <= '0;
      best_idx_q <= '0;
      best_sad_q <= 16'hFFFF;
      err_q      <= 1'b0;
    end else begin
      if (go) begin
        blk_idx_q  <= '0;
        total_q    <= '0;
        best_idx_q <= '0;
        best_sad_q <= 16'hFFFF;
        err_q      <= 1'b0;
      end
      if (state_q == S_REQ && me_ack) begin
        res_sad_q  <= me_min_sad;
        res_mvec_q <= me_min_mvec;
        res_idx_q  <= blk_idx_q;
      end
      if (state_q == S_CAPT) begin
        total_q <= total_q + {{IDX_W{1'b0}}, res_sad_q};
        if (res_sad_q < best_sad_q) begin
          best_sad_q <= res_sad_q;
          best_idx_q <= blk_idx_q;
        end
      end
      if (state_q == S_NEXT && !last_blk) blk_idx_q <= blk_idx_q + IDX_W'(1);
      if (state_d == S_ERR && state_q != S_ERR) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_me_scheduler.sv
// tb_me_scheduler: randomized engine model plus result scoreboard
// for me_scheduler (16 blocks, 64-cycle watchdog).
module tb_me_scheduler;

  localparam int NB = 16;
  localparam int IW = 4;
  localparam int TO = 64;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW-1:0] blk_idx;
  logic          me_req;
  logic          me_ack;
  logic [15:0]   me_min_sad;
  logic [9:0]    me_min_mvec;
  logic          res_valid;
  logic [IW-1:0] res_idx;
  logic [15:0]   res_sad;
  logic [9:0]    res_mvec;
  logic [19:0]   total_sad;
  logic [IW-1:0] best_idx;

  me_scheduler #(.NUM_BLK(NB), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .blk_idx(blk_idx), .me_req(me_req), .me_ack(me_ack),
    .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_valid(res_valid), .res_idx(res_idx),
    .res_sad(res_sad), .res_mvec(res_mvec),
    .total_sad(total_sad), .best_idx(best_idx)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] sad_tab [NB];
  logic [9:0]  mvec_tab[NB];

  int eng_lat  = 20;
  int eng_hold = 0;
  bit eng_dead = 0;
  int fall_cyc = 0;
  int fall_seq = 0;

  int rcount = 0;
  int ndone  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Engine: acks eng_lat cycles into a request, releases eng_hold
  // cycles after req drops; data comes from the bank named by blk_idx.
  initial begin
    int cnt;
    cnt = 0;
    me_ack = 0;
    me_min_sad = 0;
    me_min_mvec = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        me_ack = 0;
        cnt = 0;
      end else if (!me_ack) begin
        if (me_req && !eng_dead) begin
          cnt++;
          if (cnt >= eng_lat) begin
            me_ack = 1;
            me_min_sad = sad_tab[blk_idx];
            me_min_mvec = mvec_tab[blk_idx];
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else if (!me_req) begin
        cnt++;
        if (cnt > eng_hold) begin
          me_ack = 0;
          me_min_sad = 16'($urandom);
          me_min_mvec = 10'($urandom);
          cnt = 0;
          fall_cyc = cyc;
          fall_seq++;
        end
      end
    end
  end

  // Monitor: result stream order/content, re-request spacing, watchdog span.
  initial begin
    bit busy_p, req_p;
    int rise_cyc, used_seq;
    busy_p = 0;
    req_p = 0;
    rise_cyc = 0;
    used_seq = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_p) begin
        rcount = 0;
        used_seq = fall_seq;
      end
      if (res_valid) begin
        if (rcount < NB) begin
          chk("res_idx", 32'(res_idx), 32'(rcount));
          chk("res_sad", 32'(res_sad), 32'(sad_tab[rcount]));
          chk("res_mvec", 32'(res_mvec), 32'(mvec_tab[rcount]));
        end else begin
          chk("res_extra", 32'(rcount + 1), 32'(NB));
        end
        rcount++;
      end
      if (me_req && !req_p) begin
        rise_cyc = cyc;
        chk("req_idx", 32'(blk_idx), 32'(rcount));
        if (used_seq != fall_seq) begin
          chk("req_gap", 32'(cyc - fall_cyc), 32'd3);
          used_seq = fall_seq;
        end
      end
      if (!me_req && req_p && eng_dead)
        chk("wdog_len", 32'(cyc - rise_cyc), 32'(TO));
      if (done) ndone++;
      busy_p = busy;
      req_p = me_req;
    end
  end

  task automatic fill(input int mode);
    for (int i = 0; i < NB; i++) begin
      mvec_tab[i] = 10'($urandom);
      case (mode)
        0: sad_tab[i] = 16'($urandom_range(121, 65535));
        1: sad_tab[i] = 16'hFFFF;
        default: sad_tab[i] = 16'($urandom_range(0, 15) * 1000 +
                                  $urandom_range(0, 3));
      endcase
    end
    if (mode == 0) begin
      sad_tab[0] = 16'd300;
      sad_tab[1] = 16'd120;
      sad_tab[2] = 16'd120;
      sad_tab[3] = 16'd500;
    end
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1;
  endtask

  task automatic run_wait(input int budget, input bit poke);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      start = poke && !seen && ($urandom_range(0, 3) == 0);
    end
    start = 0;
    chk("run_end", 32'(seen), 32'd1);
  endtask

  task automatic check_run(input int done0);
    logic [19:0] tot;
    logic [15:0] mn;
    int bi;
    tot = 0;
    mn = 16'hFFFF;
    bi = -1;
    for (int i = 0; i < NB; i++) begin
      tot += 20'(sad_tab[i]);
      if (sad_tab[i] < mn) mn = sad_tab[i];
    end
    for (int i = NB - 1; i >= 0; i--)
      if (sad_tab[i] == mn) bi = i;
    @(negedge clk);
    chk("total_sad", 32'(total_sad), 32'(tot));
    chk("best_idx", 32'(best_idx), 32'(bi));
    chk("res_cnt", 32'(rcount), 32'(NB));
    chk("done_cnt", 32'(ndone), 32'(done0 + 1));
    chk("err_clr", 32'(err), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, n;
    rst = 1;
    start = 0;
    fill(2);
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(me_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_idx", 32'(blk_idx), 32'd0);
    chk("rst_tot", 32'(total_sad), 32'd0);
    chk("rst_best", 32'(best_idx), 32'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    // fixed-latency run with the tie pattern in the first blocks
    fill(0);
    eng_lat = 20;
    eng_hold = 0;
    d0 = ndone;
    kick();
    run_wait(4000, 0);
    check_run(d0);

    // long ack release plus start spam during the run
    fill(2);
    eng_lat = $urandom_range(1, 30);
    eng_hold = 10;
    d0 = ndone;
    kick();
    run_wait(4000, 1);
    check_run(d0);

    // saturated SADs: no wrap of the running total
    fill(1);
    eng_lat = $urandom_range(1, 8);
    eng_hold = $urandom_range(0, 4);
    d0 = ndone;
    kick();
    run_wait(4000, 0);
    check_run(d0);

    // engine never answers: watchdog abort
    eng_dead = 1;
    d0 = ndone;
    kick();
    run_wait(1000, 0);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_res", 32'(rcount), 32'd0);
    chk("to_done", 32'(ndone), 32'(d0 + 1));
    eng_dead = 0;

    // next start clears err, then runs normally
    fill(2);
    eng_lat = $urandom_range(1, 30);
    eng_hold = $urandom_range(0, 20);
    d0 = ndone;
    kick();
    @(negedge clk);
    start = 0;
    chk("err_start", 32'(err), 32'd0);
    chk("busy_start", 32'(busy), 32'd1);
    run_wait(4000, 0);
    check_run(d0);

    // asynchronous reset in the middle of a request
    fill(2);
    eng_lat = 20;
    eng_hold = 2;
    kick();
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(rcount >= 2 && me_req) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait", 32'(n < 2000), 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_req", 32'(me_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_idx", 32'(blk_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    fill(2);
    eng_lat = $urandom_range(1, 30);
    eng_hold = $urandom_range(0, 20);
    d0 = ndone;
    kick();
    run_wait(4000, 0);
    check_run(d0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
